// File: rtl/dmx121_seq_if.sv
// rtl/dmx121_seq_if.sv - slot stream and frame output bundle for the 12:1 demultiplexer
// Signals:
//   d, d_valid, sync, clr_err  : incoming slot word stream and error clear (driven by master)
//   y0..y11                    : registered frame outputs, slot n of the last complete frame
//   s                          : slot index of the next expected word (upstream mux select)
//   frame_valid, locked        : one-cycle publish strobe, frame alignment held
//   sync_err                   : sticky alignment error flag
interface dmx121_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             sync;
    logic             clr_err;
    logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11;
    logic [3:0]       s;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;

    modport master (
        output d, d_valid, sync, clr_err,
        input  y0, y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11,
        input  s, frame_valid, locked, sync_err
    );

    modport slave (
        input  d, d_valid, sync, clr_err,
        output y0, y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11,
        output s, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/dmx121_seq.sv
// rtl/dmx121_seq.sv - 12:1 word demultiplexer with SYNC-aligned frame sequencer
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmx121_seq_if.slave (slot stream in, frame outputs / status out)
module dmx121_seq #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    dmx121_seq_if.slave   bus
);

    localparam logic [3:0] LAST = 4'(NUM_CH - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t           state, state_n;
    logic [3:0]       s_q, s_n;
    logic [WIDTH-1:0] sh  [NUM_CH-1];
    logic [WIDTH-1:0] y_q [NUM_CH];
    logic             frame_valid_q;
    logic             sync_err_q;

    logic             sh_we;
    logic [3:0]       sh_idx;
    logic             publish;
    logic             err_set;

    // A SYNC word always lands in sh0, whatever slot we thought we were in.
    always_comb begin
        state_n = state;
        s_n     = s_q;
        sh_we   = 1'b0;
        publish = 1'b0;
        err_set = 1'b0;
        sh_idx  = bus.sync ? 4'd0 : s_q;
        if (bus.d_valid) begin
            case (state)
                HUNT: begin
                    if (bus.sync) begin
                        sh_we   = 1'b1;
                        s_n     = 4'd1;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (bus.sync) begin
                        // Early SYNC re-aligns; the partial frame is simply overwritten.
                        sh_we   = 1'b1;
                        s_n     = 4'd1;
                        err_set = (s_q != 4'd0);
                    end else if (s_q == 4'd0) begin
                        err_set = 1'b1;
                        state_n = HUNT;
                    end else if (s_q == LAST) begin
                        // The last word goes straight to its output, no shadow slot.
                        publish = 1'b1;
                        s_n     = 4'd0;
                    end else begin
                        sh_we = 1'b1;
                        s_n   = s_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HUNT;
            s_q           <= 4'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < NUM_CH - 1; i++) sh[i] <= '0;
            for (int i = 0; i < NUM_CH; i++) y_q[i] <= '0;
        end else begin
            state         <= state_n;
            s_q           <= s_n;
            frame_valid_q <= publish;
            // Set has priority over clear on the same edge.
            sync_err_q    <= err_set | (sync_err_q & ~bus.clr_err);
            if (sh_we) sh[sh_idx] <= bus.d;
            if (publish) begin
                for (int i = 0; i < NUM_CH - 1; i++) y_q[i] <= sh[i];
                y_q[NUM_CH-1] <= bus.d;
            end
        end
    end

    assign bus.y0          = y_q[0];
    assign bus.y1          = y_q[1];
    assign bus.y2          = y_q[2];
    assign bus.y3          = y_q[3];
    assign bus.y4          = y_q[4];
    assign bus.y5          = y_q[5];
    assign bus.y6          = y_q[6];
    assign bus.y7          = y_q[7];
    assign bus.y8          = y_q[8];
    assign bus.y9          = y_q[9];
    assign bus.y10         = y_q[10];
    assign bus.y11         = y_q[11];
    assign bus.s           = s_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = (state == RUN);
    assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_dmx121_seq.sv
// tb/tb_dmx121_seq.sv - scoreboard testbench for dmx121_seq
module tb_dmx121_seq;

    typedef logic [11:0][15:0] frame_t;

    logic clk;
    logic rst_n;

    dmx121_seq_if #(.WIDTH(16)) ifc ();

    dmx121_seq #(.WIDTH(16), .NUM_CH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: the frame in progress as a list of words.
    logic [15:0] words [$];
    frame_t      exp_q [$];
    frame_t      last_pub;
    logic        m_locked;
    logic        m_err;
    logic        m_fv;

    frame_t cur;
    always_comb begin
        cur[0]  = ifc.y0;  cur[1]  = ifc.y1;  cur[2]  = ifc.y2;  cur[3]  = ifc.y3;
        cur[4]  = ifc.y4;  cur[5]  = ifc.y5;  cur[6]  = ifc.y6;  cur[7]  = ifc.y7;
        cur[8]  = ifc.y8;  cur[9]  = ifc.y9;  cur[10] = ifc.y10; cur[11] = ifc.y11;
    end

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic dv, input logic sy, input logic [15:0] dd, input logic clr);
        bit     set;
        frame_t f;
        set  = 1'b0;
        m_fv = 1'b0;
        if (dv) begin
            if (!m_locked) begin
                if (sy) begin
                    words.delete();
                    words.push_back(dd);
                    m_locked = 1'b1;
                end
            end else if (sy) begin
                if (words.size() != 0) set = 1'b1;
                words.delete();
                words.push_back(dd);
            end else if (words.size() == 0) begin
                set      = 1'b1;
                m_locked = 1'b0;
            end else begin
                words.push_back(dd);
                if (words.size() == 12) begin
                    for (int i = 0; i < 12; i++) f[i] = words[i];
                    exp_q.push_back(f);
                    words.delete();
                    m_fv = 1'b1;
                end
            end
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic cyc(input logic dv, input logic sy, input logic [15:0] dd, input logic clr);
        @(negedge clk);
        ifc.d_valid = dv;
        ifc.sync    = sy;
        ifc.d       = dd;
        ifc.clr_err = clr;
        model_step(dv, sy, dd, clr);
        @(posedge clk);
        #1;
        chk("s", ifc.s, 192'(words.size()));
        chk("locked", ifc.locked, m_locked);
        chk("sync_err", ifc.sync_err, m_err);
        chk("frame_valid", ifc.frame_valid, m_fv);
    endtask

    task automatic do_reset();
        ifc.d_valid = 1'b0;
        ifc.sync    = 1'b0;
        ifc.d       = '0;
        ifc.clr_err = 1'b0;
        rst_n       = 1'b0;
        words.delete();
        exp_q.delete();
        last_pub = '0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_fv     = 1'b0;
        #1;
        chk("rst_y", cur, '0);
        chk("rst_s", ifc.s, 0);
        chk("rst_fv", ifc.frame_valid, 0);
        chk("rst_locked", ifc.locked, 0);
        chk("rst_err", ifc.sync_err, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] base, input int gap_slot, input int gap_len);
        for (int n = 0; n < 12; n++) begin
            cyc(1'b1, n == 0, base + 16'(n), 1'b0);
            if (n == gap_slot) repeat (gap_len) cyc(1'b0, 1'b0, 16'h0, 1'b0);
        end
    endtask

    // Monitor: every published frame must match the oldest expected one,
    // and between strobes the outputs must hold the last published frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.frame_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_frame", 1, 0);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    chk("frame_y", cur, f);
                    last_pub = f;
                end
            end else begin
                chk("y_hold", cur, last_pub);
            end
        end
    end

    initial begin
        logic dv, sy, clr;
        rst_n       = 1'b1;
        ifc.d_valid = 1'b0;
        ifc.sync    = 1'b0;
        ifc.d       = '0;
        ifc.clr_err = 1'b0;
        #2;
        do_reset();
        repeat (2) cyc(1'b0, 1'b0, 16'h0, 1'b0);

        send_frame(16'h0000, -1, 0);
        send_frame(16'h0000, 5, 3);
        send_frame(16'h0080, -1, 0);
        send_frame(16'h0100, -1, 0);

        // Early SYNC at slot 7, then a clean frame from the re-sync word.
        for (int n = 0; n < 7; n++) cyc(1'b1, n == 0, 16'h0300 + 16'(n), 1'b0);
        send_frame(16'h0200, -1, 0);

        // Slot 0 without SYNC while locked; clear on the same edge loses to set.
        cyc(1'b1, 1'b0, 16'hdead, 1'b1);
        for (int n = 0; n < 4; n++) cyc(1'b1, 1'b0, 16'h0400 + 16'(n), 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        send_frame(16'h0500, -1, 0);

        // Asynchronous reset in the middle of a frame.
        for (int n = 0; n < 4; n++) cyc(1'b1, n == 0, 16'h0600 + 16'(n), 1'b0);
        #2;
        do_reset();
        send_frame(16'h0700, -1, 0);

        for (int c = 0; c < 1500; c++) begin
            dv  = ($urandom_range(0, 9) < 8);
            if (words.size() == 0) sy = ($urandom_range(0, 19) != 0);
            else                   sy = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 29) == 0);
            cyc(dv, sy, 16'($urandom), clr);
        end

        repeat (3) cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmx121_seq.md
Name: dmx121_seq

Overview:
- Receive-side counterpart of the 12:1 16-bit word multiplexer.
- Accepts a time-division stream of one 16-bit word per slot, with a SYNC marker on slot 0.
- Tracks slot position with a frame sequencer and deserializes 12 consecutive words into 12 parallel registered outputs.
- Publishes each completed frame atomically with a one-cycle FRAME_VALID strobe; drives the current slot index back out as a 4-bit select for the upstream mux.

Parameters:
- WIDTH, 16, data word width for D and Y0..Y11.
- NUM_CH, 12, slots per frame. Fixed at 12 because the port list is fixed; must be ≤ 16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  WIDTH  incoming slot word.
- D_VALID  input  1  D is valid this cycle; one word is consumed per cycle in which it is high.
- SYNC  input  1  qualifies D as slot 0; sampled only when D_VALID=1.
- CLR_ERR  input  1  synchronous clear of SYNC_ERR.
- Y0..Y11  output  WIDTH each  registered frame outputs; Yn holds slot n of the last complete frame.
- S  output  4  slot index of the next expected word; feeds the upstream mux select.
- FRAME_VALID  output  1  one-cycle pulse; Y0..Y11 were updated on the edge that raised it.
- LOCKED  output  1  high in RUN state.
- SYNC_ERR  output  1  sticky alignment-error flag.

Behaviour:
- Reset (async assert, rst_n=0):
  - Y0..Y11=0, S=0, FRAME_VALID=0, LOCKED=0, SYNC_ERR=0.
  - Shadow registers sh0..sh10 = 0; state = HUNT.
  - Reset mid-frame discards the partial frame. Y outputs return to 0, not to the last published frame.
- States: HUNT, RUN. S is the slot counter, range 0..11, and is 0 whenever in HUNT.
- HUNT:
  - D_VALID=1 & SYNC=1: sh0←D, S←1, go to RUN.
  - D_VALID=1 & SYNC=0: word dropped; stay in HUNT.
  - D_VALID=0: hold.
- RUN, D_VALID=0: hold all state. Gaps of any length are legal mid-frame.
- RUN, D_VALID=1, SYNC=0, 1≤S≤10: sh[S]←D, S←S+1.
- RUN, D_VALID=1, SYNC=0, S=11 (frame completion):
  - On the same edge: Y0..Y10←sh0..sh10, Y11←D, S←0, FRAME_VALID←1.
  - Latency is one edge from the slot-11 word to visible outputs.
  - All 12 Y outputs change on the same edge; no partial updates are ever visible.
- RUN, D_VALID=1, S=0, SYNC=1: sh0←D, S←1 (normal frame start).
- RUN, D_VALID=1, S=0, SYNC=0:
  - Set SYNC_ERR, drop the word, go to HUNT (LOCKED←0).
  - Y outputs keep the last published frame.
- RUN, D_VALID=1, SYNC=1, S≠0 (early SYNC):
  - Set SYNC_ERR; discard sh contents collected so far (not published).
  - Re-align: sh0←D, S←1, stay in RUN.
- FRAME_VALID:
  - High for exactly one cycle after each completion.
  - Back-to-back frames with D_VALID held high give a pulse every 12 cycles.
- SYNC_ERR:
  - Stays set until CLR_ERR=1 or reset.
  - If CLR_ERR and a new error occur on the same edge, the set wins (flag stays 1).
- Shadow registers are not cleared at frame completion; stale values are always overwritten before the next publish.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset release, then 12 words 0x0000..0x000B with D_VALID=1 and SYNC on the first → FRAME_VALID pulses once, one cycle after the 12th word. Y0=0x0000 … Y11=0x000B. S sequence 0,1,…,11,0. LOCKED=1 from the edge after word 0.
- Same frame with D_VALID low for 3 cycles after slot 5 → identical Y values. S holds at 6 during the gap. FRAME_VALID is delayed by exactly 3 cycles.
- Two back-to-back frames, second with words 0x0100+n → FRAME_VALID pulses 12 cycles apart. After the second pulse Yn=0x0100+n, and Y never shows a mix of old and new values.
- SYNC asserted on slot 7, then 12 clean words 0x0200+n → SYNC_ERR=1, no FRAME_VALID for the aborted frame. Frame from the re-sync word publishes Yn=0x0200+n.
- Locked, slot 0 arrives with SYNC=0 → SYNC_ERR=1, LOCKED=0, S=0, Y unchanged. Words without SYNC are ignored until SYNC. CLR_ERR=1 for one cycle → SYNC_ERR=0.
- rst_n pulsed low asynchronously (between clock edges) at slot 4 → all outputs 0 immediately. A following full frame publishes correctly with no residue from the aborted frame.
